axil_csr_bank: RTL
==================

# axil_csr_bank

Parametrised AXI4-Lite control/status register bank for the CentralControlUnit and any future accelerator core. It is the next generation of the CCU register file. Register count, data width and per-register access mode are set by parameters. AW and W channels are accepted independently. Write-1-to-clear event registers feed a maskable interrupt, and out-of-range or illegal accesses return SLVERR. It sits between the PS AXI-Lite interconnect and the PL control FSMs.

## Interface
- NUM_REGS, 16: number of registers; word index range 0..NUM_REGS-1.
- DATA_WIDTH, 32: register and AXI data width; 32 or 64 only.
- ADDR_WIDTH, 8: AXI byte-address width; must be ≥ clog2(NUM_REGS)+clog2(DATA_WIDTH/8).
- RO_MASK, 0: bit r=1 makes register r read-only (value is reg_in[r]).
- W1C_MASK, 0: bit r=1 makes register r a write-1-to-clear event register (bits are set by PL).
- RESET_VALUE, 0: NUM_REGS*DATA_WIDTH flat reset image for RW registers.
- IRQ_EN_IDX, NUM_REGS-1: index of the RW interrupt-enable register.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axil_aw{addr,prot,valid,ready}, s_axil_w{data,strb,valid,ready}, s_axil_b{resp,valid,ready}, s_axil_ar{addr,prot,valid,ready}, s_axil_r{data,resp,valid,ready}: standard AXI4-Lite slave.
  - Widths are ADDR_WIDTH, 3, DATA_WIDTH and DATA_WIDTH/8.
  - prot is ignored.
- reg_out  out  NUM_REGS*DATA_WIDTH  current value of every register.
- reg_in  in  NUM_REGS*DATA_WIDTH  PL data.
  - RO register: sampled every cycle.
  - W1C register: OR-set when reg_in_we[r]=1.
  - RW register: loaded when reg_in_we[r]=1.
- reg_in_we  in  NUM_REGS  per-register PL write/set strobe; ignored for RO registers.
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse in the cycle after a successful PS write commits.
- reg_rd_pulse  out  NUM_REGS  one-cycle pulse when a PS read of r is accepted; used to pop or ack.
- irq  out  1  level interrupt, registered.

## Operation
- Word index = addr >> clog2(DATA_WIDTH/8). Low address bits are ignored.
- Write path: an AW holding register and a W holding register, filled independently.
  - awready = AW hold empty.
  - wready = W hold empty.
  - Commit when both holds are full and (!bvalid || bready).
  - Commit clears both holds and sets bvalid.
- Commit effect, by register mode:
  - RW register: byte-masked by wstrb; bresp=OKAY.
  - W1C register: clear bits in (wdata & strb-expanded mask); bresp=OKAY.
  - RO register or index ≥ NUM_REGS: no state change; bresp=SLVERR (2'b10).
- Read path:
  - arready = !rvalid || rready.
  - On acceptance, rdata/rresp are registered and rvalid=1 the next cycle.
  - Index ≥ NUM_REGS returns rdata=0 with rresp=SLVERR.
  - rvalid holds until rready.
- RO register value: reg_in registered once, so reg_out lags reg_in by 1 cycle.
- irq = |(OR over W1C registers of reg & IRQ_EN register), registered.
- Collisions on the same bit in the same cycle:
  - W1C register, PL set vs PS clear: set wins.
  - RW register, PL write vs PS commit: PS wins, and reg_wr_pulse fires.

## Timing
- While rst_n=0, all ready/valid/pulse outputs and irq are 0.
- Under reset, RW registers load RESET_VALUE and W1C registers load 0.
- awready/wready/arready go 1 on the first clk edge after rst_n rises.
- Reset asserted mid-transaction drops all holds and pending B/R responses; no partial writes are applied.
- Write latency, AW and W both in cycle 0:
  - commit in cycle 1;
  - bvalid and new reg_out in cycle 2;
  - reg_wr_pulse in cycle 2.
- AW arriving N cycles before W: commit happens the cycle after W is accepted.
- A second AW is back-pressured until the commit.
- Read latency: AR accepted in cycle 0, rvalid in cycle 1.
- Back-to-back reads are sustained at 1 per cycle while rready=1.
- irq lags the causing register change by 1 cycle.

## Configuration
- AXIL_CSR_BANK_IRQ_EN defined:
  - W1C_MASK and IRQ_EN_IDX are active;
  - irq is generated as described.
- AXIL_CSR_BANK_IRQ_EN undefined:
  - irq is tied to 0;
  - W1C registers behave as RW registers, with byte-masked writes and PL load via reg_in_we;
  - the IRQ_EN_IDX register is an ordinary RW register.

## Test plan
- Reset behaviour: RESET_VALUE reg2=0xA5A5_0000 → after rst_n rises, read of 0x08 returns 0xA5A5_0000 with OKAY; irq=0.
- Skewed write: AW(0x04) in cycle 0, W(0x1234_5678, strb 0b0011) in cycle 3 → bvalid in cycle 5, reg1 low half=0x5678, upper half unchanged, reg_wr_pulse[1] in cycle 5.
- RO and out-of-range accesses (RO_MASK bit 3, NUM_REGS=16):
  - write to 0x0C → SLVERR, reg3 still equals reg_in;
  - read of 0x40 → rdata 0, SLVERR.
- W1C and irq path, with IRQ_EN=0x1:
  - PL sets bit0 of W1C reg5 → irq=1 one cycle later;
  - PS writes 0x1 to 0x14 → irq=0.
  - PL set and PS clear in the same cycle → bit stays 1.
- Back-pressure: bready=0 for 4 cycles after the first write; a second AW/W is held, with no commit until bready=1.
  - Read with rready=0 holds rdata stable.
- Reset mid-write: assert rst_n=0 with AW held and W pending → no register change, bvalid=0 after release.

Source files
------------

// File: rtl/axil_csr_bank_if.sv
// AXI4-Lite slave channel bundle for axil_csr_bank.
interface axil_csr_bank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_csr_bank.sv
// axil_csr_bank: parametrised AXI4-Lite CSR bank with RW, RO and W1C registers.
// Optional feature macro: AXIL_CSR_BANK_IRQ_EN enables W1C registers and the irq output;
// when undefined, W1C registers behave as RW and irq is tied low.
module axil_csr_bank #(
  parameter int                             NUM_REGS    = 16,
  parameter int                             DATA_WIDTH  = 32,
  parameter int                             ADDR_WIDTH  = 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]            W1C_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                             IRQ_EN_IDX  = NUM_REGS-1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axil_csr_bank_if.slave                 s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  input  logic [NUM_REGS-1:0]            reg_in_we,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  output logic [NUM_REGS-1:0]            reg_rd_pulse,
  output logic                           irq
);
  localparam int STRB_WIDTH = DATA_WIDTH/8;
  localparam int BSHIFT     = $clog2(STRB_WIDTH);
  localparam int IW         = ADDR_WIDTH - BSHIFT;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXIL_CSR_BANK_IRQ_EN
  localparam logic [NUM_REGS-1:0] W1C_EFF = W1C_MASK;
`else
  localparam logic [NUM_REGS-1:0] W1C_EFF = '0;
`endif

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  live;
  logic                  aw_full, w_full;
  logic [IW-1:0]         aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_fire, w_fire, ar_fire, commit;
  logic [IW-1:0]         ar_idx;
  logic [NUM_REGS-1:0]   aw_hit, ar_hit, wr_sel;
  logic [DATA_WIDTH-1:0] ar_data, bmask, wr_bits;
  logic                  unused_bits;

  assign s_axil.awready = live && !aw_full;
  assign s_axil.wready  = live && !w_full;
  assign s_axil.arready = live && (!rvalid_q || s_axil.rready);
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;

  assign aw_fire = s_axil.awvalid && s_axil.awready;
  assign w_fire  = s_axil.wvalid && s_axil.wready;
  assign ar_fire = s_axil.arvalid && s_axil.arready;
  assign commit  = aw_full && w_full && (!bvalid_q || s_axil.bready);
  assign ar_idx  = s_axil.araddr[ADDR_WIDTH-1:BSHIFT];
  assign wr_bits = w_data & bmask;
  assign reg_rd_pulse = ar_fire ? ar_hit : '0;

  assign unused_bits = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[BSHIFT-1:0],
                         s_axil.araddr[BSHIFT-1:0], reg_in_we & RO_MASK};

  // Decode held write index and read index; out-of-range leaves the hit vector empty
  always_comb begin
    aw_hit  = '0;
    ar_hit  = '0;
    ar_data = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (32'(aw_idx) == r) aw_hit[r] = 1'b1;
      if (32'(ar_idx) == r) begin
        ar_hit[r] = 1'b1;
        ar_data   = regs[r];
      end
    end
    wr_sel = commit ? (aw_hit & ~RO_MASK) : '0;
  end

  // Expand write strobes to a bit mask and flatten the register array
  always_comb begin
    bmask   = '0;
    reg_out = '0;
    for (int unsigned b = 0; b < STRB_WIDTH; b++) bmask[b*8 +: 8] = {8{w_strb[b]}};
    for (int unsigned r = 0; r < NUM_REGS; r++) reg_out[r*DATA_WIDTH +: DATA_WIDTH] = regs[r];
  end

  // AW/W holding registers, B response, R response and ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live     <= 1'b0;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      live <= 1'b1;
      if (aw_fire) begin
        aw_full <= 1'b1;
        aw_idx  <= s_axil.awaddr[ADDR_WIDTH-1:BSHIFT];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_fire) begin
        w_full <= 1'b1;
        w_data <= s_axil.wdata;
        w_strb <= s_axil.wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (|wr_sel) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil.bready) begin
        bvalid_q <= 1'b0;
      end
      if (ar_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= ar_data;
        rresp_q  <= (|ar_hit) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Register storage: RO samples reg_in, W1C set beats PS clear, RW PS commit beats PL load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        regs[r] <= (RO_MASK[r] || W1C_EFF[r]) ? '0 : RESET_VALUE[r*DATA_WIDTH +: DATA_WIDTH];
      reg_wr_pulse <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (RO_MASK[r])
          regs[r] <= reg_in[r*DATA_WIDTH +: DATA_WIDTH];
        else if (W1C_EFF[r])
          regs[r] <= (regs[r] & ~(wr_sel[r] ? wr_bits : '0))
                   | (reg_in_we[r] ? reg_in[r*DATA_WIDTH +: DATA_WIDTH] : '0);
        else if (wr_sel[r])
          regs[r] <= (regs[r] & ~bmask) | wr_bits;
        else if (reg_in_we[r])
          regs[r] <= reg_in[r*DATA_WIDTH +: DATA_WIDTH];
      end
      reg_wr_pulse <= wr_sel;
    end
  end

`ifdef AXIL_CSR_BANK_IRQ_EN
  logic [DATA_WIDTH-1:0] w1c_or;

  // Merge all W1C event registers into one pending vector
  always_comb begin
    w1c_or = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++)
      if (W1C_EFF[r]) w1c_or = w1c_or | regs[r];
  end

  // Registered level interrupt from pending events masked by the enable register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |(w1c_or & regs[IRQ_EN_IDX]);
  end
`else
  assign irq = 1'b0;
`endif
endmodule
